// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core control FSM: state codes, trap causes and PC helpers.
// Optional instret counter is enabled by defining BURV_INSTRET_EN.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_FETCH = 2'd0,
        CTRL_EXEC0 = 2'd1,
        CTRL_EXEC1 = 2'd2,
        CTRL_MEM   = 2'd3
    } ctrl_state_e;

    localparam logic [3:0]  MCAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0]  MCAUSE_EBREAK  = 4'd3;
    localparam logic [3:0]  MCAUSE_ECALL_M = 4'd11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] insn_len(input logic compressed);
        return compressed ? 32'd2 : 32'd4;
    endfunction

    // Targets are halfword aligned; bit 1 survives so RVC destinations stay reachable.
    function automatic logic [31:0] align_half(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFE;
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Instruction-memory fetch port between the control FSM (master) and the memory (slave).
// Part of the core_ctrl slice; see core_ctrl.sv for the BURV_INSTRET_EN option.
interface core_ctrl_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_rvalid,
        input  instr_rdata
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_rvalid,
        output instr_rdata
    );

endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle fetch/execute/commit sequencer: owns the PC, gates side effects, raises traps.
// Define BURV_INSTRET_EN to add the 64-bit retired-instruction counter output instret_o.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,

    core_ctrl_if.master        instr_bus,

    output logic [31:0]        instr_o,
    output logic [31:0]        pc_o,
    output logic               cycle_counter_o,

    input  logic               compressed_i,
    input  logic               jump_i,
    input  logic               branch_i,
    input  logic               lsu_req_i,
    input  logic               ecall_i,
    input  logic               ebreak_i,
    input  logic               mret_i,
    input  logic               illegal_i,
    input  logic [31:0]        alu_result_i,
    input  logic               lsu_done_i,
    input  logic [31:0]        mtvec_i,
    input  logic [31:0]        mepc_i,

    output logic               exec_en_o,
    output logic               trap_o,
    output logic [31:0]        trap_mepc_o,
    output logic [3:0]         trap_mcause_o
`ifdef BURV_INSTRET_EN
    ,
    output logic [63:0]        instret_o
`endif
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q;
    logic [31:0] pc_seq;
    logic        exec_en;
    logic        trap;
    logic [3:0]  trap_cause;
    logic        fetch_hit;

    assign pc_seq    = pc_q + insn_len(compressed_i);
    assign fetch_hit = (state_q == CTRL_FETCH) && instr_bus.instr_rvalid;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        exec_en    = 1'b0;
        trap       = 1'b0;
        trap_cause = '0;

        unique case (state_q)
            CTRL_FETCH: begin
                if (fetch_hit) begin
                    state_d = CTRL_EXEC0;
                end
            end

            CTRL_EXEC0: begin
                if (illegal_i || ecall_i || ebreak_i) begin
                    // Precise trap: side effects stay gated off for the faulting instruction.
                    trap    = 1'b1;
                    pc_d    = align_half(mtvec_i);
                    state_d = CTRL_FETCH;
                    if (illegal_i) begin
                        trap_cause = MCAUSE_ILLEGAL;
                    end else if (ecall_i) begin
                        trap_cause = MCAUSE_ECALL_M;
                    end else begin
                        trap_cause = MCAUSE_EBREAK;
                    end
                end else if (mret_i) begin
                    exec_en = 1'b1;
                    pc_d    = align_half(mepc_i);
                    state_d = CTRL_FETCH;
                end else if (jump_i) begin
                    exec_en = 1'b1;
                    state_d = CTRL_EXEC1;
                end else if (branch_i) begin
                    if (alu_result_i[0]) begin
                        state_d = CTRL_EXEC1;
                    end else begin
                        pc_d    = pc_seq;
                        state_d = CTRL_FETCH;
                    end
                end else if (lsu_req_i) begin
                    exec_en = 1'b1;
                    if (lsu_done_i) begin
                        pc_d    = pc_seq;
                        state_d = CTRL_FETCH;
                    end else begin
                        state_d = CTRL_MEM;
                    end
                end else begin
                    exec_en = 1'b1;
                    pc_d    = pc_seq;
                    state_d = CTRL_FETCH;
                end
            end

            CTRL_EXEC1: begin
                pc_d    = align_half(alu_result_i);
                state_d = CTRL_FETCH;
            end

            CTRL_MEM: begin
                exec_en = 1'b1;
                if (lsu_done_i) begin
                    pc_d    = pc_seq;
                    state_d = CTRL_FETCH;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CTRL_FETCH;
            pc_q    <= BOOT_ADDR;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetch_hit) begin
                instr_q <= instr_bus.instr_rdata;
            end
        end
    end

`ifdef BURV_INSTRET_EN
    logic [63:0] instret_q;
    logic        retire;

    // An instruction retires when an execute state hands back to FETCH without trapping.
    assign retire = (state_q != CTRL_FETCH) && (state_d == CTRL_FETCH) && !trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

    assign instr_bus.instr_req  = (state_q == CTRL_FETCH);
    assign instr_bus.instr_addr = pc_q;

    assign instr_o         = instr_q;
    assign pc_o            = pc_q;
    assign cycle_counter_o = (state_q == CTRL_EXEC1);
    assign exec_en_o       = exec_en;
    assign trap_o          = trap;
    assign trap_mepc_o     = trap ? pc_q : '0;
    assign trap_mcause_o   = trap_cause;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: each cycle's expected outputs are queued, then popped and compared.
// Builds with or without BURV_INSTRET_EN; the counter port is only connected when defined.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_ctrl_if bus ();

    logic [31:0] instr_o, pc_o, alu_result_i, mtvec_i, mepc_i, trap_mepc_o;
    logic        cycle_counter_o, exec_en_o, trap_o;
    logic        compressed_i, jump_i, branch_i, lsu_req_i;
    logic        ecall_i, ebreak_i, mret_i, illegal_i, lsu_done_i;
    logic [3:0]  trap_mcause_o;
`ifdef BURV_INSTRET_EN
    logic [63:0] instret_o;
`endif

    core_ctrl #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_bus       (bus),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .cycle_counter_o (cycle_counter_o),
        .compressed_i    (compressed_i),
        .jump_i          (jump_i),
        .branch_i        (branch_i),
        .lsu_req_i       (lsu_req_i),
        .ecall_i         (ecall_i),
        .ebreak_i        (ebreak_i),
        .mret_i          (mret_i),
        .illegal_i       (illegal_i),
        .alu_result_i    (alu_result_i),
        .lsu_done_i      (lsu_done_i),
        .mtvec_i         (mtvec_i),
        .mepc_i          (mepc_i),
        .exec_en_o       (exec_en_o),
        .trap_o          (trap_o),
        .trap_mepc_o     (trap_mepc_o),
        .trap_mcause_o   (trap_mcause_o)
`ifdef BURV_INSTRET_EN
        ,
        .instret_o       (instret_o)
`endif
    );

    typedef struct packed {
        logic        req;
        logic        en;
        logic        cc;
        logic        trap;
        logic [3:0]  mcause;
        logic [31:0] mepc;
        logic [31:0] pc;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic req, input logic en, input logic cc,
                            input logic trap, input logic [3:0] mcause, input logic [31:0] pc);
        obs_t e;
        e.req    = req;
        e.en     = en;
        e.cc     = cc;
        e.trap   = trap;
        e.mcause = mcause;
        e.mepc   = trap ? pc : 32'h0;
        e.pc     = pc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sample();
        obs_t  e;
        string t;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".req"},    {31'b0, bus.instr_req},   {31'b0, e.req});
        check({t, ".en"},     {31'b0, exec_en_o},       {31'b0, e.en});
        check({t, ".cc"},     {31'b0, cycle_counter_o}, {31'b0, e.cc});
        check({t, ".trap"},   {31'b0, trap_o},          {31'b0, e.trap});
        check({t, ".mcause"}, {28'b0, trap_mcause_o},   {28'b0, e.mcause});
        check({t, ".mepc"},   trap_mepc_o,              e.mepc);
        check({t, ".pc"},     pc_o,                     e.pc);
        check({t, ".addr"},   bus.instr_addr,           e.pc);
    endtask

    task automatic fetch_cyc(input string tag, input logic [31:0] pc);
        push_exp(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, pc);
        sample();
    endtask

    task automatic exec_cyc(input string tag, input logic en, input logic cc, input logic [31:0] pc);
        push_exp(tag, 1'b0, en, cc, 1'b0, 4'd0, pc);
        sample();
    endtask

    task automatic trap_cyc(input string tag, input logic [3:0] mcause, input logic [31:0] pc);
        push_exp(tag, 1'b0, 1'b0, 1'b0, 1'b1, mcause, pc);
        sample();
    endtask

    task automatic clear_dec();
        compressed_i = 1'b0;
        jump_i       = 1'b0;
        branch_i     = 1'b0;
        lsu_req_i    = 1'b0;
        ecall_i      = 1'b0;
        ebreak_i     = 1'b0;
        mret_i       = 1'b0;
        illegal_i    = 1'b0;
        lsu_done_i   = 1'b0;
        alu_result_i = 32'h0;
        mtvec_i      = 32'h0;
        mepc_i       = 32'h0;
    endtask

    // One-cycle fetch at pc; returns at the EXEC0 negedge with the word already latched.
    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] word);
        @(negedge clk);
        clear_dec();
        bus.instr_rvalid = 1'b1;
        bus.instr_rdata  = word;
        fetch_cyc({tag, ".fetch"}, pc);
        @(negedge clk);
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = 32'h0;
        check({tag, ".instr"}, instr_o, word);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = 32'h0;
        clear_dec();

        repeat (2) @(negedge clk);
        fetch_cyc("reset", 32'h0);
        check("reset.instr", instr_o, NOP_INSTR);
        rst_n = 1'b1;

        // Fetch stalls one cycle with req held, then ADDI commits in EXEC0.
        @(negedge clk);
        fetch_cyc("addi.wait", 32'h0);
        fetch("addi", 32'h0, 32'h0010_0093);
        exec_cyc("addi.ex0", 1'b1, 1'b0, 32'h0);

        fetch("mret1", 32'h4, 32'h3020_0073);
        mret_i = 1'b1;
        mepc_i = 32'h11;
        exec_cyc("mret1.ex0", 1'b1, 1'b0, 32'h4);

        // C.ADDI with a stray rvalid during EXEC0 that must not overwrite instr_o.
        fetch("caddi", 32'h10, 32'h0000_0505);
        compressed_i     = 1'b1;
        bus.instr_rvalid = 1'b1;
        bus.instr_rdata  = 32'hDEAD_BEEF;
        exec_cyc("caddi.ex0", 1'b1, 1'b0, 32'h10);
        @(negedge clk);
        bus.instr_rvalid = 1'b0;
        check("caddi.ignore", instr_o, 32'h0000_0505);

        fetch("jal", 32'h12, 32'h0000_006F);
        jump_i = 1'b1;
        exec_cyc("jal.ex0", 1'b1, 1'b0, 32'h12);
        @(negedge clk);
        alu_result_i = 32'h203;
        exec_cyc("jal.ex1", 1'b0, 1'b1, 32'h12);

        fetch("mret2", 32'h202, 32'h3020_0073);
        mret_i = 1'b1;
        mepc_i = 32'h40;
        exec_cyc("mret2.ex0", 1'b1, 1'b0, 32'h202);

        fetch("beq_nt", 32'h40, 32'h0000_0063);
        branch_i = 1'b1;
        exec_cyc("beq_nt.ex0", 1'b0, 1'b0, 32'h40);

        fetch("beq_t", 32'h44, 32'h0000_0063);
        branch_i     = 1'b1;
        alu_result_i = 32'h1;
        exec_cyc("beq_t.ex0", 1'b0, 1'b0, 32'h44);
        @(negedge clk);
        alu_result_i = 32'h80;
        exec_cyc("beq_t.ex1", 1'b0, 1'b1, 32'h44);

        // Load finishing in the third MEM cycle: exec_en high for four cycles.
        fetch("lw", 32'h80, 32'h0000_A083);
        lsu_req_i = 1'b1;
        exec_cyc("lw.ex0", 1'b1, 1'b0, 32'h80);
        @(negedge clk);
        exec_cyc("lw.mem1", 1'b1, 1'b0, 32'h80);
        @(negedge clk);
        exec_cyc("lw.mem2", 1'b1, 1'b0, 32'h80);
        @(negedge clk);
        lsu_done_i = 1'b1;
        exec_cyc("lw.mem3", 1'b1, 1'b0, 32'h80);

        fetch("sw", 32'h84, 32'h0010_A023);
        lsu_req_i  = 1'b1;
        lsu_done_i = 1'b1;
        exec_cyc("sw.ex0", 1'b1, 1'b0, 32'h84);

        fetch("mret3", 32'h88, 32'h3020_0073);
        mret_i = 1'b1;
        mepc_i = 32'h100;
        exec_cyc("mret3.ex0", 1'b1, 1'b0, 32'h88);

        fetch("illegal", 32'h100, 32'h0000_0000);
        illegal_i = 1'b1;
        mtvec_i   = 32'h201;
        trap_cyc("illegal.ex0", MCAUSE_ILLEGAL, 32'h100);

        fetch("ecall", 32'h200, 32'h0000_0073);
        ecall_i = 1'b1;
        mtvec_i = 32'h300;
        trap_cyc("ecall.ex0", MCAUSE_ECALL_M, 32'h200);

        // EBREAK outranks a simultaneous jump: no EXEC1 follows.
        fetch("ebreak", 32'h300, 32'h0010_0073);
        ebreak_i = 1'b1;
        jump_i   = 1'b1;
        mtvec_i  = 32'h400;
        trap_cyc("ebreak.ex0", MCAUSE_EBREAK, 32'h300);

        fetch("mret4", 32'h400, 32'h3020_0073);
        mret_i = 1'b1;
        mepc_i = 32'h104;
        exec_cyc("mret4.ex0", 1'b1, 1'b0, 32'h400);

        fetch("mret5", 32'h104, 32'h3020_0073);
        mret_i = 1'b1;
        mepc_i = 32'hFFFF_FFFC;
        exec_cyc("mret5.ex0", 1'b1, 1'b0, 32'h104);

        fetch("wrap", 32'hFFFF_FFFC, 32'h0010_0093);
        exec_cyc("wrap.ex0", 1'b1, 1'b0, 32'hFFFF_FFFC);

        fetch("mret6", 32'h0, 32'h3020_0073);
        mret_i = 1'b1;
        mepc_i = 32'h500;
        exec_cyc("mret6.ex0", 1'b1, 1'b0, 32'h0);

        // Reset asserted while the load waits in MEM.
        fetch("lw2", 32'h500, 32'h0000_A083);
        lsu_req_i = 1'b1;
        exec_cyc("lw2.ex0", 1'b1, 1'b0, 32'h500);
        @(negedge clk);
        exec_cyc("lw2.mem1", 1'b1, 1'b0, 32'h500);
        @(negedge clk);
        rst_n = 1'b0;
        fetch_cyc("lw2.rst", 32'h0);
        check("lw2.rst.instr", instr_o, NOP_INSTR);
        rst_n = 1'b1;

        fetch("post_rst", 32'h0, 32'h0010_0093);
        exec_cyc("post_rst.ex0", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        clear_dec();
        fetch_cyc("final", 32'h4);

        check("scoreboard.drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
